if_id_buffer: RTL

IF_ID_BUFFER -- requirements
Module: if_id_buffer

---
 rtl/if_id_buffer_pkg.sv | 15 +
 rtl/if_id_buffer.sv | 80 ++++++++
 2 files changed

// File: rtl/if_id_buffer_pkg.sv
// Shared MIPS pipeline constants and helpers for the fetch/decode boundary.
package if_id_buffer_pkg;

  localparam int          DATA_W_DEF   = 32;
  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;
  localparam int          IFID_DEPTH   = 2;

  typedef logic [1:0] ifid_count_t;

  // One-bit pointers naturally wrap 1 -> 0.
  function automatic logic ptr_inc(input logic ptr);
    return ~ptr;
  endfunction

endpackage

// File: rtl/if_id_buffer.sv
// Two-entry skid buffer between fetch and decode; in_ready comes only from
// registered occupancy so decode stalls never ripple combinationally into fetch.
module if_id_buffer
  import if_id_buffer_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] instruction,
  input  logic [DATA_W-1:0] pc_plus4,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_instruction,
  output logic [DATA_W-1:0] out_pc_plus4,
  output logic [1:0]        occupancy
);

  ifid_count_t       count_q, count_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0] instr_mem_q [IFID_DEPTH];
  logic [DATA_W-1:0] pc_mem_q    [IFID_DEPTH];

  logic push, pop;

  assign in_ready  = (count_q < ifid_count_t'(IFID_DEPTH));
  assign out_valid = (count_q != 2'd0);
  assign occupancy = count_q;

  assign push = in_valid  && in_ready  && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Storage is never cleared; count and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= instruction;
      pc_mem_q[wr_ptr_q]    <= pc_plus4;
    end
  end

  assign out_instruction = out_valid ? instr_mem_q[rd_ptr_q] : NOP_WORD;
  assign out_pc_plus4    = out_valid ? pc_mem_q[rd_ptr_q]    : '0;

endmodule
